// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the 8-bit alu and its command
//                sequencer: opcode encodings, sequencer FSM states and the
//                command-entry layout held in the command FIFO.
//                ALU_SEQ_CHAIN_EN adds a chain bit to each command entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_LAND = 4'd10;
    localparam logic [3:0] OP_LOR  = 4'd11;
    localparam logic [3:0] OP_LNOT = 4'd12;
    localparam logic [3:0] OP_EQ   = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_LT   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [3:0]            sel;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
`ifdef ALU_SEQ_CHAIN_EN
        logic                  chain;
`endif
    } alu_cmd_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous FIFO for sequencer commands. Pushes beyond full
//                and pops from empty are ignored. Read data is presented
//                from the head entry without a read-latency cycle.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                push/push_data - write an entry
//                pop/pop_data   - remove head entry / head entry contents
//                full, empty, count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Command front-end for the combinational alu. Buffers
//                {sel, a, b} commands in a FIFO, issues one at a time through
//                registered operand outputs and captures alu_y into a result
//                register with a valid/ready output.
//                Optional macro ALU_SEQ_CHAIN_EN: a command with in_chain=1
//                uses the low half of the previous result as operand a.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                in_valid/in_ready/in_sel/in_a/in_b/in_chain - command input
//                alu_a/alu_b/alu_sel, alu_y    - alu operands and result
//                res_valid/res_ready/res_data/res_sel - result output
//                busy                          - work queued or in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_sel,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic                  in_chain,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [3:0]            alu_sel,
    input  logic [2*DATA_W-1:0]   alu_y,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_W-1:0]   res_data,
    output logic [3:0]            res_sel,
    output logic                  busy
);

    localparam int ENTRY_W = $bits(alu_cmd_t);

    seq_state_t               r_state;
    alu_cmd_t                 w_push_cmd;
    alu_cmd_t                 w_pop_cmd;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_push;
    logic                     w_pop;
    logic [DATA_W-1:0]        w_next_a;

`ifdef ALU_SEQ_CHAIN_EN
    logic [2*DATA_W-1:0]      r_last_res;
    logic                     w_unused_last_hi;
    // Only the low half of the previous result feeds operand a.
    assign w_unused_last_hi = ^r_last_res[2*DATA_W-1:DATA_W];
`else
    logic                     w_unused_chain;
    assign w_unused_chain = in_chain;
`endif

    always_comb begin
        w_push_cmd     = '0;
        w_push_cmd.sel = in_sel;
        w_push_cmd.a   = in_a;
        w_push_cmd.b   = in_b;
`ifdef ALU_SEQ_CHAIN_EN
        w_push_cmd.chain = in_chain;
`endif
    end

    always_comb begin
        w_next_a = w_pop_cmd.a;
`ifdef ALU_SEQ_CHAIN_EN
        if (w_pop_cmd.chain) begin
            w_next_a = r_last_res[DATA_W-1:0];
        end
`endif
    end

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    // Pop from IDLE, or from HOLD on the edge the held result is taken.
    assign w_pop    = !w_empty &&
                      ((r_state == IDLE) || ((r_state == HOLD) && res_ready));
    assign busy     = (w_count != '0) || (r_state != IDLE);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_pop_cmd),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            r_last_res <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        alu_a   <= w_next_a;
                        alu_b   <= w_pop_cmd.b;
                        alu_sel <= w_pop_cmd.sel;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_y;
                    res_sel   <= alu_sel;
                    res_valid <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
                    r_last_res <= alu_y;
`endif
                    r_state   <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (w_pop) begin
                            alu_a   <= w_next_a;
                            alu_b   <= w_pop_cmd.b;
                            alu_sel <= w_pop_cmd.sel;
                            r_state <= EXEC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Directed self-checking bench for alu_cmd_sequencer with a
//                behavioural alu attached to the operand/result ports.
//                Honours ALU_SEQ_CHAIN_EN for the chained-operand case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sel;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_chain;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_sel;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] got_data[$];
    logic [3:0]  got_sel[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_chain  (in_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sel   (res_sel),
        .busy      (busy)
    );

    function automatic logic [15:0] alu_model(input logic [3:0] s,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (s)
            OP_ADD:  return wa + wb;
            OP_SUB:  return wa - wb;
            OP_MUL:  return wa * wb;
            OP_AND:  return wa & wb;
            OP_OR:   return wa | wb;
            OP_NOT:  return ~wa;
            OP_XOR:  return wa ^ wb;
            OP_XNOR: return ~(wa ^ wb);
            OP_SHL:  return wa << b[3:0];
            OP_SHR:  return wa >> b[3:0];
            OP_LAND: return {15'd0, (a != 8'd0) && (b != 8'd0)};
            OP_LOR:  return {15'd0, (a != 8'd0) || (b != 8'd0)};
            OP_LNOT: return {15'd0, a == 8'd0};
            OP_EQ:   return {15'd0, a == b};
            OP_GT:   return {15'd0, a > b};
            default: return {15'd0, a < b};
        endcase
    endfunction

    always_comb alu_y = alu_model(alu_sel, alu_a, alu_b);

    // Record every result handshake that will occur at the next rising edge.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            got_data.push_back(res_data);
            got_sel.push_back(res_sel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic [7:0] a,
                        input logic [7:0] b, input logic c);
        int cyc = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_a     = a;
        in_b     = b;
        in_chain = c;
        while (!in_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check("push_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int cyc = 0;
        while (got_data.size() < n && cyc < 200) begin
            tick();
            cyc++;
        end
        check("result_count", got_data.size(), n);
    endtask

    task automatic clear_results();
        got_data.delete();
        got_sel.delete();
    endtask

    logic [15:0] sweep_exp [16] = '{16'd18, 16'd12, 16'd45, 16'd3, 16'd15,
                                    16'hFFF0, 16'd12, 16'hFFF3, 16'd120, 16'd1,
                                    16'd1, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0};
    logic [15:0] bp_exp  [5]  = '{16'd2, 16'd5, 16'd42, 16'h00FF, 16'h0055};
    logic [3:0]  bp_sel  [5]  = '{OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_OR};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_a      = '0;
        in_b      = '0;
        in_chain  = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_res_data",  {16'd0, res_data},  32'd0);
        check("rst_alu_a",     {24'd0, alu_a},     32'd0);
        check("rst_alu_sel",   {28'd0, alu_sel},   32'd0);

        // Single ADD: 2-cycle latency from acceptance
        push(OP_ADD, 8'd15, 8'd3, 1'b0);
        check("add_e0_res_valid", {31'd0, res_valid}, 32'd0);
        check("add_e0_busy",      {31'd0, busy},      32'd1);
        tick();
        check("add_e1_alu_a",     {24'd0, alu_a},     32'd15);
        check("add_e1_alu_b",     {24'd0, alu_b},     32'd3);
        check("add_e1_res_valid", {31'd0, res_valid}, 32'd0);
        tick();
        check("add_e2_res_valid", {31'd0, res_valid}, 32'd1);
        check("add_e2_res_data",  {16'd0, res_data},  32'd18);
        check("add_e2_res_sel",   {28'd0, res_sel},   32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("add_done_res_valid", {31'd0, res_valid}, 32'd0);
        check("add_done_busy",      {31'd0, busy},      32'd0);
        clear_results();

        // Opcode sweep with the consumer always ready
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(4'(i), 8'd15, 8'd3, 1'b0);
        end
        wait_results(16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("sweep_data_%0d", i), {16'd0, got_data[i]}, {16'd0, sweep_exp[i]});
            check($sformatf("sweep_sel_%0d", i),  {28'd0, got_sel[i]},  i);
        end
        tick();
        tick();
        res_ready = 1'b0;
        clear_results();

        // Backpressure: one held result plus four queued fills the sequencer
        push(OP_ADD, 8'd1,   8'd1,   1'b0);
        push(OP_SUB, 8'd9,   8'd4,   1'b0);
        push(OP_MUL, 8'd7,   8'd6,   1'b0);
        push(OP_XOR, 8'hF0,  8'h0F,  1'b0);
        push(OP_OR,  8'h50,  8'h05,  1'b0);
        check("full_in_ready",  {31'd0, in_ready},  32'd0);
        check("full_res_valid", {31'd0, res_valid}, 32'd1);
        check("full_busy",      {31'd0, busy},      32'd1);
        // An offered command while full must not be taken
        in_valid = 1'b1;
        in_sel   = OP_ADD;
        in_a     = 8'hAA;
        in_b     = 8'hAA;
        tick();
        tick();
        in_valid = 1'b0;
        check("full_in_ready_hold", {31'd0, in_ready}, 32'd0);

        // Stall stability across 10 cycles
        for (int i = 0; i < 10; i++) tick();
        check("stall_res_valid", {31'd0, res_valid}, 32'd1);
        check("stall_res_data",  {16'd0, res_data},  32'd2);
        check("stall_res_sel",   {28'd0, res_sel},   32'd0);
        check("stall_alu_a",     {24'd0, alu_a},     32'd1);
        check("stall_alu_b",     {24'd0, alu_b},     32'd1);
        check("stall_alu_sel",   {28'd0, alu_sel},   32'd0);

        // Drain in order
        res_ready = 1'b1;
        tick();
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        wait_results(5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_data_%0d", i), {16'd0, got_data[i]}, {16'd0, bp_exp[i]});
            check($sformatf("drain_sel_%0d", i),  {28'd0, got_sel[i]},  {28'd0, bp_sel[i]});
        end
        tick();
        tick();
        check("drain_extra", got_data.size(), 5);
        check("drain_busy",  {31'd0, busy}, 32'd0);
        clear_results();

        // Chained operand
        push(OP_MUL, 8'd15, 8'd3, 1'b0);
        push(OP_ADD, 8'd7,  8'd5, 1'b1);
        wait_results(2);
        check("chain_first", {16'd0, got_data[0]}, 32'd45);
`ifdef ALU_SEQ_CHAIN_EN
        check("chain_second", {16'd0, got_data[1]}, 32'd50);
`else
        check("chain_second", {16'd0, got_data[1]}, 32'd12);
`endif
        tick();
        tick();
        res_ready = 1'b0;
        clear_results();

        // Reset while in EXEC with two entries queued
        push(OP_ADD, 8'd1, 8'd2, 1'b0);
        push(OP_ADD, 8'd3, 8'd4, 1'b0);
        push(OP_ADD, 8'd5, 8'd6, 1'b0);
        res_ready = 1'b1;
        push(OP_ADD, 8'd7, 8'd8, 1'b0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        res_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_res_data",  {16'd0, res_data},  32'd0);
        check("mid_rst_alu_a",     {24'd0, alu_a},     32'd0);
        clear_results();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_no_results", got_data.size(), 0);
        check("post_rst_res_valid",  {31'd0, res_valid}, 32'd0);
        res_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
